// File: rtl/ps2_rx_fifo.sv
// PS/2 receiver: synchronizes the device clock/data, assembles 11-bit frames and queues
// scan codes in a small FIFO. Define PS2_RX_FRAME_CHECK_EN to reject bad start/stop/parity.
module ps2_rx_fifo #(
    parameter int unsigned FIFO_AW     = 3,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] scan_code,
    output logic       ready,
    output logic       overflow
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CW    = FIFO_AW + 1;
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);

    logic [2:0]         r_clk_sync;
    logic [2:0]         r_dat_sync;
    logic [9:0]         r_shift;
    logic [3:0]         r_bitcnt;
    logic [TO_W-1:0]    r_to;
    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [CW-1:0]      r_count;
    logic               r_overflow;

    logic        w_fall;
    logic [10:0] w_frame;
    logic        w_done;
    logic        w_timeout;
    logic        w_accept;
    logic        w_full;
    logic        w_pop;
    logic        w_push;

    assign w_fall    = (r_clk_sync[2:1] == 2'b10);
    assign w_frame   = {r_dat_sync[2], r_shift};
    assign w_done    = w_fall && (r_bitcnt == 4'd10);
    assign w_timeout = (r_bitcnt != 4'd0) && (r_to == TO_W'(TIMEOUT_CYC));

`ifdef PS2_RX_FRAME_CHECK_EN
    assign w_accept = !w_frame[0] && w_frame[10] && (^w_frame[9:1]);
`else
    logic w_unused_frame_bits;
    assign w_unused_frame_bits = ^{w_frame[10:9], w_frame[0]};
    assign w_accept = 1'b1;
`endif

    assign ready     = (r_count != '0);
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_pop     = !nextdata_n && ready;
    // A simultaneous pop frees a slot, so a full FIFO can still take the frame.
    assign w_push    = w_done && w_accept && (!w_full || w_pop);
    assign scan_code = r_mem[r_rptr];
    assign overflow  = r_overflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_sync <= 3'b111;
            r_dat_sync <= 3'b111;
        end else begin
            r_clk_sync <= {r_clk_sync[1:0], ps2_clk};
            r_dat_sync <= {r_dat_sync[1:0], ps2_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_to     <= '0;
        end else if (w_fall) begin
            r_shift  <= w_frame[10:1];
            r_bitcnt <= w_done ? 4'd0 : r_bitcnt + 4'd1;
            r_to     <= '0;
        end else if (r_bitcnt == 4'd0) begin
            r_to <= '0;
        end else if (w_timeout) begin
            r_bitcnt <= '0;
            r_to     <= '0;
        end else begin
            r_to <= r_to + TO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= 8'h00;
            r_wptr <= '0;
        end else if (w_push) begin
            r_mem[r_wptr] <= w_frame[8:1];
            r_wptr        <= r_wptr + FIFO_AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_pop) r_rptr <= r_rptr + FIFO_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_done && w_accept && w_full && !w_pop) r_overflow <= 1'b1;
            else if (w_pop)                             r_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: frame table, directed corner sequences and random
// traffic against a queue-based reference model.
module tb_ps2_rx_fifo;

    localparam int unsigned TO   = 200;
    localparam int          HALF = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic       nextdata_n;
    logic [7:0] scan_code;
    logic       ready;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    bit         ovf;

    ps2_rx_fifo #(
        .FIFO_AW    (3),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .nextdata_n(nextdata_n),
        .scan_code (scan_code),
        .ready     (ready),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        bit         bad_par;
        bit         bad_stop;
        bit         exp_ready;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] build(input logic [7:0] d, input bit bp, input bit bs);
        logic [10:0] f;
        f[0]    = 1'b0;
        f[8:1]  = d;
        f[9]    = ~(^d) ^ bp;
        f[10]   = ~bs;
        return f;
    endfunction

    function automatic bit frame_ok(input logic [10:0] f);
`ifdef PS2_RX_FRAME_CHECK_EN
        return (f[0] == 1'b0) && f[10] && (^f[9:1]);
`else
        return (f !== 11'bx) || 1'b1;
`endif
    endfunction

    // mode 0: plain, 1: pop aligned with completion edge, 2: check push latency
    task automatic send_bits(input logic [10:0] f, input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ps2_data = f[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == 10 && mode == 1) begin
                @(negedge clk);
                @(negedge clk);
                if (q.size() != 0) chk("sync_pop_code", scan_code, q[0]);
                nextdata_n = 1'b0;
                @(negedge clk);
                nextdata_n = 1'b1;
                repeat (HALF - 3) @(negedge clk);
            end else if (i == 10 && mode == 2) begin
                @(negedge clk);
                @(negedge clk);
                chk("lat_early", ready, 0);
                @(negedge clk);
                chk("lat_ready", ready, 1);
                repeat (HALF - 3) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            ps2_clk = 1'b1;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bp, input bit bs, input int mode);
        logic [10:0] f;
        bit          was_full;
        bit          popped;
        f        = build(d, bp, bs);
        send_bits(f, 11, mode);
        was_full = (q.size() == 8);
        popped   = 1'b0;
        if (mode == 1 && q.size() != 0) begin
            void'(q.pop_front());
            ovf    = 1'b0;
            popped = 1'b1;
        end
        if (frame_ok(f)) begin
            if (!was_full || popped) q.push_back(d);
            else ovf = 1'b1;
        end
    endtask

    task automatic do_pop();
        @(negedge clk);
        chk("pop_ready", ready, q.size() != 0);
        if (q.size() != 0) chk("pop_code", scan_code, q[0]);
        nextdata_n = 1'b0;
        @(negedge clk);
        nextdata_n = 1'b1;
        if (q.size() != 0) begin
            void'(q.pop_front());
            ovf = 1'b0;
        end
        chk("pop_ovf", overflow, ovf);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_code", scan_code, 8'h00);
        rst_n = 1'b1;
        q.delete();
        ovf = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        tbl[0] = '{8'h1C, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{8'h00, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{8'hFF, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{8'hF0, 1'b0, 1'b0, 1'b1};
`ifdef PS2_RX_FRAME_CHECK_EN
        tbl[4] = '{8'hF0, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{8'hA5, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{8'h3C, 1'b1, 1'b1, 1'b0};
`else
        tbl[4] = '{8'hF0, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{8'hA5, 1'b0, 1'b1, 1'b1};
        tbl[6] = '{8'h3C, 1'b1, 1'b1, 1'b1};
`endif

        rst_n      = 1'b0;
        ps2_clk    = 1'b1;
        ps2_data   = 1'b1;
        nextdata_n = 1'b1;
        ovf        = 1'b0;
        do_reset();

        // Single frame with exact push latency, then pop back to empty.
        send_frame(8'h1C, 1'b0, 1'b0, 2);
        chk("one_ready", ready, 1);
        chk("one_code", scan_code, 8'h1C);
        do_pop();
        chk("one_empty", ready, 0);

        for (int i = 0; i < 7; i++) begin
            send_frame(tbl[i].data, tbl[i].bad_par, tbl[i].bad_stop, 0);
            chk($sformatf("tbl%0d_ready", i), ready, tbl[i].exp_ready);
            if (tbl[i].exp_ready) begin
                chk($sformatf("tbl%0d_code", i), scan_code, tbl[i].data);
                do_pop();
            end
        end

        // Nine frames into an eight-deep FIFO.
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0, 0);
        chk("ovf_set", overflow, 1);
        for (int i = 0; i < 8; i++) do_pop();
        chk("ovf_drain_empty", ready, 0);

        // Partial frame abandoned by timeout.
        send_bits(build(8'hE7, 1'b0, 1'b0), 5, 0);
        repeat (TO + 20) @(negedge clk);
        send_frame(8'h5A, 1'b0, 1'b0, 0);
        chk("to_code", scan_code, 8'h5A);
        do_pop();
        chk("to_no_extra", ready, 0);

        // Full FIFO, completion coincident with pop.
        for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b0, 0);
        chk("full_ovf0", overflow, 0);
        send_frame(8'h33, 1'b0, 1'b0, 1);
        chk("sync_ovf", overflow, 0);
        chk("sync_ready", ready, 1);
        for (int i = 0; i < 7; i++) do_pop();
        chk("sync_last", scan_code, 8'h33);
        do_pop();
        chk("sync_empty", ready, 0);

        // Reset in the middle of a frame.
        send_bits(build(8'h99, 1'b0, 1'b0), 6, 0);
        do_reset();
        send_frame(8'h76, 1'b0, 1'b0, 0);
        chk("mid_rst_code", scan_code, 8'h76);
        chk("mid_rst_ready", ready, 1);
        chk("mid_rst_ovf", overflow, 0);
        do_pop();

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                do_pop();
            end else begin
                send_frame(8'($urandom), $urandom_range(0, 4) == 0, 1'b0, 0);
                chk("rnd_ready", ready, q.size() != 0);
                chk("rnd_ovf", overflow, ovf);
                if (q.size() != 0) chk("rnd_head", scan_code, q[0]);
            end
        end
        while (q.size() != 0) do_pop();
        chk("rnd_empty", ready, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
